tx_gearbox: RTL and testbench

//  Transmit-side 64b/66b gearbox feeding the 128-bit GT tx_data port, on the tx_clk (usrclk2) domain.

---
 rtl/tx_gearbox_if.sv | 11 +
 rtl/tx_gearbox.sv | 74 +++++++
 tb/tb_tx_gearbox.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/tx_gearbox_if.sv
// User-side handshake bundle for the 64b/66b transmit gearbox.
// The producer drives two payload blocks and their headers each cycle; the gearbox returns ready.
interface tx_gearbox_if;
  logic [127:0] data_in;
  logic [3:0]   hdr_in;
  logic         valid_in;
  logic         ready_out;

  modport master (output data_in, output hdr_in, output valid_in, input ready_out);
  modport slave  (input data_in, input hdr_in, input valid_in, output ready_out);
endinterface

// File: rtl/tx_gearbox.sv
// Transmit 64b/66b gearbox: packs 132-bit units (two headered blocks) into a gapless 128-bit GT stream.
// The user side is paused once every PERIOD cycles while the residual buffer drains.
module tx_gearbox #(
  parameter logic [63:0] IDLE_PAYLOAD = 64'h0000_0000_0000_001E,
  parameter int          PERIOD       = 33
) (
  input  logic          clk,
  input  logic          rst,
  tx_gearbox_if.slave   u,
  output logic [127:0]  gt_data,
  output logic          hdr_err
);

  localparam logic [5:0] SEQ_LAST = 6'(PERIOD - 1);

  logic [5:0]   r_seq;
  logic [127:0] r_res;
  logic [127:0] r_gt_data_p1;
  logic         r_hdr_err_p1;

  logic         w_ready;
  logic [131:0] w_unit;
  logic [255:0] w_shift;
  logic [127:0] w_word;
  logic [127:0] w_res_nxt;
  logic         w_err;

  function automatic logic hdr_bad(input logic [1:0] h);
    return (h == 2'b00) || (h == 2'b11);
  endfunction

  function automatic logic [131:0] build_unit(input logic v, input logic [3:0] h,
                                              input logic [127:0] d);
    if (v)
      return {d[127:64], h[3:2], d[63:0], h[1:0]};
    return {IDLE_PAYLOAD, 2'b10, IDLE_PAYLOAD, 2'b10};
  endfunction

  assign w_ready     = !rst && (r_seq != SEQ_LAST);
  assign u.ready_out = w_ready;

  // Stage 0: place the new unit above the 4*seq residual bits and split at bit 128
  always_comb begin
    w_unit    = build_unit(u.valid_in, u.hdr_in, u.data_in);
    w_shift   = {124'b0, w_unit} << {r_seq, 2'b00};
    w_word    = r_res;
    w_res_nxt = '0;
    w_err     = 1'b0;
    if (w_ready) begin
      w_word    = w_shift[127:0] | r_res;
      w_res_nxt = w_shift[255:128];
      w_err     = u.valid_in && (hdr_bad(u.hdr_in[1:0]) || hdr_bad(u.hdr_in[3:2]));
    end
  end

  // Stage 1: registered GT word and header-error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seq        <= '0;
      r_res        <= '0;
      r_gt_data_p1 <= '0;
      r_hdr_err_p1 <= 1'b0;
    end else begin
      r_seq        <= (r_seq == SEQ_LAST) ? 6'd0 : r_seq + 6'd1;
      r_res        <= w_res_nxt;
      r_gt_data_p1 <= w_word;
      r_hdr_err_p1 <= w_err;
    end
  end

  assign gt_data = r_gt_data_p1;
  assign hdr_err = r_hdr_err_p1;

endmodule

// File: tb/tb_tx_gearbox.sv
// Bench for tx_gearbox: a bit-queue stream model checks every GT word, plus directed corner sequences.
module tb_tx_gearbox;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] gt_data;
  logic         hdr_err;

  tx_gearbox_if g ();

  tx_gearbox dut (
    .clk     (clk),
    .rst     (rst),
    .u       (g.slave),
    .gt_data (gt_data),
    .hdr_err (hdr_err)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int phase  = 0;
  bit q[$];

  typedef struct packed {
    logic       v;
    logic [3:0] hdr;
    logic       err;
  } vec_t;
  vec_t tbl[8];

  localparam logic [63:0] IDLE = 64'h1E;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic bad(input logic [1:0] h);
    return (h == 2'b00) || (h == 2'b11);
  endfunction

  task automatic step(input logic v, input logic [3:0] h, input logic [127:0] d);
    logic         exp_rdy;
    logic         exp_err;
    logic [131:0] unit;
    logic [127:0] exp_word;
    g.valid_in = v;
    g.hdr_in   = h;
    g.data_in  = d;
    #1;
    exp_rdy = (phase != 32);
    chk("ready_out", {127'b0, g.ready_out}, {127'b0, exp_rdy});
    exp_err = 1'b0;
    if (exp_rdy) begin
      unit = v ? {d[127:64], h[3:2], d[63:0], h[1:0]} : {IDLE, 2'b10, IDLE, 2'b10};
      for (int i = 0; i < 132; i++) q.push_back(unit[i]);
      exp_err = v && (bad(h[1:0]) || bad(h[3:2]));
    end
    @(posedge clk);
    #1;
    phase = (phase == 32) ? 0 : phase + 1;
    chk("hdr_err", {127'b0, hdr_err}, {127'b0, exp_err});
    if (q.size() < 128) begin
      n_cmp++;
      n_fail++;
      $display("FAIL stream_underflow: queue has %0d bits, need 128", q.size());
    end else begin
      for (int i = 0; i < 128; i++) exp_word[i] = q.pop_front();
      chk("gt_data", gt_data, exp_word);
    end
  endtask

  task automatic do_reset();
    g.valid_in = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_ready", {127'b0, g.ready_out}, 128'd0);
    @(posedge clk);
    #1;
    chk("rst_gt_data", gt_data, 128'd0);
    chk("rst_hdr_err", {127'b0, hdr_err}, 128'd0);
    rst = 1'b0;
    q.delete();
    phase = 0;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] d3;
    d3 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

    tbl[0] = '{v: 1'b1, hdr: 4'b0101, err: 1'b0};
    tbl[1] = '{v: 1'b1, hdr: 4'b1101, err: 1'b1};
    tbl[2] = '{v: 1'b1, hdr: 4'b0110, err: 1'b0};
    tbl[3] = '{v: 1'b1, hdr: 4'b0000, err: 1'b1};
    tbl[4] = '{v: 1'b0, hdr: 4'b1111, err: 1'b0};
    tbl[5] = '{v: 1'b1, hdr: 4'b1001, err: 1'b0};
    tbl[6] = '{v: 1'b1, hdr: 4'b0111, err: 1'b1};
    tbl[7] = '{v: 1'b1, hdr: 4'b1010, err: 1'b0};

    g.valid_in = 1'b0;
    g.hdr_in   = 4'b0;
    g.data_in  = '0;
    @(posedge clk);
    #1;
    do_reset();

    // First accept after reset: hand-computed word
    step(1'b1, 4'b1001, d3);
    chk("first_word", gt_data, {60'h1234_5678_9AB_CDEF, 2'b10, 64'hFEDC_BA98_7654_3210, 2'b01});

    // Idle-only run across two full periods
    do_reset();
    for (int i = 0; i < 66; i++) step(1'b0, 4'b0, rnd128());

    // Header-error table
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].v, tbl[i].hdr, rnd128());
      chk($sformatf("tbl_err[%0d]", i), {127'b0, hdr_err}, {127'b0, tbl[i].err});
    end
    while (phase != 32) step(1'b1, 4'b0101, rnd128());
    step(1'b1, 4'b1111, rnd128());
    chk("err_while_paused", {127'b0, hdr_err}, 128'd0);
    step(1'b1, 4'b1101, rnd128());
    chk("err_after_pause", {127'b0, hdr_err}, 128'd1);

    // Back-to-back counter data, ten periods
    do_reset();
    for (int k = 0; k < 330; k++) step(1'b1, 4'b0101, {64'(2 * k + 1), 64'(2 * k)});

    // Reset in the middle of a period
    do_reset();
    for (int i = 0; i < 17; i++) step($urandom_range(0, 1) == 1, 4'(2'b01 + $urandom_range(0, 1) * 5), rnd128());
    do_reset();
    for (int i = 0; i < 80; i++) step($urandom_range(0, 1) == 1, 4'b1001, rnd128());

    // Random 50% valid traffic
    for (int i = 0; i < 150; i++) step($urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), rnd128());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
